// File: rtl/general_register_file.sv
// Eight 32-bit x86 GPRs with sized multi-port reads/writes and a per-register busy scoreboard.
// Optional same-cycle write forwarding to read ports: define GPR_WRITE_BYPASS_EN.
module general_register_file #(
    parameter int unsigned READ_PORTS  = 3,
    parameter int unsigned WRITE_PORTS = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [READ_PORTS-1:0][2:0]        read_index,
    input  logic [READ_PORTS-1:0][1:0]        read_size,
    output logic [READ_PORTS-1:0][31:0]       read_data,
    output logic [READ_PORTS-1:0]             read_busy,
    input  logic [WRITE_PORTS-1:0]            write_enable,
    input  logic [WRITE_PORTS-1:0][2:0]       write_index,
    input  logic [WRITE_PORTS-1:0][1:0]       write_size,
    input  logic [WRITE_PORTS-1:0][31:0]      write_data,
    input  logic [WRITE_PORTS-1:0]            write_release,
    input  logic                              lock_valid,
    input  logic [2:0]                        lock_index,
    output logic [7:0]                        busy,
    output logic                              lock_conflict
);

    logic [7:0][31:0] regs;
    logic [7:0][31:0] merged_regs;
    logic [7:0][31:0] view_regs;
    logic [7:0]       released_busy;
    logic [7:0]       next_busy;
    logic [7:0]       view_busy;

    // Byte encodings 4-7 are the high byte of registers 0-3.
    function automatic logic [2:0] phys_of(input logic [2:0] idx, input logic [1:0] size);
        return (size == 2'b00) ? {1'b0, idx[1:0]} : idx;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] idx, input logic [1:0] size);
        case (size)
            2'b00:   return idx[2] ? 4'b0010 : 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] idx, input logic [1:0] size,
                                              input logic [31:0] data);
        if (size == 2'b00)
            return idx[2] ? {16'h0000, data[7:0], 8'h00} : {24'h000000, data[7:0]};
        else
            return data;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] idx, input logic [1:0] size,
                                            input logic [31:0] value);
        case (size)
            2'b00:   return idx[2] ? {24'h000000, value[15:8]} : {24'h000000, value[7:0]};
            2'b01:   return {16'h0000, value[15:0]};
            default: return value;
        endcase
    endfunction

    // Ports applied in ascending order so the highest-indexed port owns each overlapping lane.
    always_comb begin
        logic [2:0]  phys;
        logic [3:0]  mask;
        logic [31:0] data;
        merged_regs   = regs;
        released_busy = busy;
        phys          = '0;
        mask          = '0;
        data          = '0;
        for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
            if (write_enable[p]) begin
                phys = phys_of(write_index[p], write_size[p]);
                mask = lane_mask(write_index[p], write_size[p]);
                data = lane_data(write_index[p], write_size[p], write_data[p]);
                for (int unsigned l = 0; l < 4; l++) begin
                    if (mask[l])
                        merged_regs[phys][l*8 +: 8] = data[l*8 +: 8];
                end
                if (write_release[p])
                    released_busy[phys] = 1'b0;
            end
        end
        next_busy = released_busy;
        if (lock_valid)
            next_busy[lock_index] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs          <= '0;
            busy          <= '0;
            lock_conflict <= 1'b0;
        end else begin
            regs          <= merged_regs;
            busy          <= next_busy;
            lock_conflict <= lock_valid & busy[lock_index];
        end
    end

`ifdef GPR_WRITE_BYPASS_EN
    assign view_regs = merged_regs;
    assign view_busy = released_busy;
`else
    assign view_regs = regs;
    assign view_busy = busy;
`endif

    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int unsigned r = 0; r < READ_PORTS; r++) begin
            read_data[r] = extract(read_index[r], read_size[r],
                                   view_regs[phys_of(read_index[r], read_size[r])]);
            read_busy[r] = view_busy[phys_of(read_index[r], read_size[r])];
        end
    end

endmodule
